// File: rtl/lockpick_pkg.sv
// Shared types and constants for the parametrised lockpick challenge core.
// The COOLDOWN state exists only when LOCKPICK_COOLDOWN_EN is defined.
package lockpick_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INPUT_A,
    S_INPUT_B,
    S_HASH,
    S_COMPARE,
    S_OUTPUT
`ifdef LOCKPICK_COOLDOWN_EN
    , S_COOLDOWN
`endif
  } state_t;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_WRONG  = 2'b01;
  localparam logic [1:0] ST_WIN    = 2'b10;
  localparam logic [1:0] ST_LOCKED = 2'b11;

  localparam logic [31:0] MSG_WIN    = 32'hFACEFACE;
  localparam logic [31:0] MSG_WRONG  = 32'hBAD0BAD0;
  localparam logic [31:0] MSG_LOCKED = 32'hDEADDEAD;

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] v);
    return SBOX[{~v, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lockpick_hash_round.sv
// One combinational Feistel-style hash round over four LW-bit lanes.
module lockpick_hash_round
  import lockpick_pkg::*;
#(
  parameter int LW = 64
) (
  input  logic [LW-1:0] a_in,
  input  logic [LW-1:0] b_in,
  input  logic [LW-1:0] c_in,
  input  logic [LW-1:0] d_in,
  output logic [LW-1:0] a_out,
  output logic [LW-1:0] b_out,
  output logic [LW-1:0] c_out,
  output logic [LW-1:0] d_out
);

  logic [LW-1:0] mix;
  logic [LW-1:0] f_brot;
  logic [LW-1:0] f_rot;
  logic [LW-1:0] f_sub;
  logic [LW-1:0] a_x;

  assign mix = ((b_in ^ d_in) + (a_in | c_in)) ^ {c_in[LW/2-1:0], d_in[LW/2-1:0]};

  for (genvar i = 0; i < LW/8; i++) begin : g_byte
    assign f_brot[8*i +: 8] = {mix[8*i +: 7], mix[8*i+7]};
    assign f_sub[8*i +: 8]  = sbox_byte(f_rot[8*i +: 8]);
  end

  assign f_rot = {f_brot[LW-14:0], f_brot[LW-1:LW-13]};
  assign a_x   = a_in ^ f_sub;

  // B and D use the freshly rotated B; C accumulates A after the F mix-in.
  assign b_out = {b_in[LW/2-2:0], b_in[LW-1:LW/2-1]};
  assign c_out = c_in + a_x;
  assign d_out = ~d_in ^ b_out;
  assign a_out = {a_x[3*LW/4-1:0], a_x[LW-1:3*LW/4]};

endmodule

// File: rtl/lockpick_game_param.sv
// Lockpick challenge core: two keys in, iterative hash, compare, byte stream out.
// Optional post-lockout cooldown is compiled in with LOCKPICK_COOLDOWN_EN.
module lockpick_game_param
  import lockpick_pkg::*;
#(
  parameter int KEY_BYTES       = 32,
  parameter int ROUNDS          = 3,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int COOLDOWN_CYCLES = 1024,
  parameter logic [511:0] CHALLENGE =
    512'hCAFEBABE_12345678_DEADBEEF_FEEDFACE_C001D00D_BADC0DE5_BAADF00D_0BADBEEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       input_enable,
  input  logic [7:0] input_data,
  input  logic       output_ready,
  output logic       output_valid,
  output logic [7:0] output_data,
  output logic [1:0] status,
  output logic [2:0] attempts_left,
  output logic       busy
);

  localparam int KW = KEY_BYTES * 8;
  localparam int LW = KEY_BYTES * 2;
  localparam int CW = $clog2(KEY_BYTES);
  localparam logic [CW-1:0] LAST_BYTE  = CW'(KEY_BYTES - 1);
  localparam logic [3:0]    LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [2:0]    ATT_MAX    = 3'(MAX_ATTEMPTS);
  localparam logic [KW-1:0] TARGET     = CHALLENGE[KW-1:0];

  state_t state, state_nxt;

  logic [KW-1:0] key_a, key_b, key_b_wr;
  logic [LW-1:0] ha, hb, hc, hd;
  logic [LW-1:0] ra, rb, rc, rd;
  logic [CW-1:0] cnt;
  logic [3:0]    rcnt;
  logic [1:0]    status_r;
  logic [2:0]    att;
  logic [2:0]    att_dec;
  logic [31:0]   msg;
  logic          in_fire, last_in, out_fire, last_out, match;

`ifdef LOCKPICK_COOLDOWN_EN
  logic [31:0] cd_timer;
`endif

  assign in_fire  = input_enable && (state == S_INPUT_A || state == S_INPUT_B);
  assign last_in  = in_fire && (cnt == LAST_BYTE);
  assign out_fire = (state == S_OUTPUT) && output_ready;
  assign last_out = out_fire && (cnt == LAST_BYTE);
  assign match    = ({ha, hb, hc, hd} == TARGET);
  assign att_dec  = (att != 3'd0) ? att - 3'd1 : 3'd0;

  assign status        = status_r;
  assign attempts_left = att;

  // The final key-B byte is merged combinationally so hashing starts on that edge.
  always_comb begin
    key_b_wr = key_b;
    key_b_wr[{cnt, 3'b000} +: 8] = input_data;
  end

  lockpick_hash_round #(.LW(LW)) u_round (
    .a_in  (ha),
    .b_in  (hb),
    .c_in  (hc),
    .d_in  (hd),
    .a_out (ra),
    .b_out (rb),
    .c_out (rc),
    .d_out (rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    output_valid = 1'b0;
    output_data  = 8'h00;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE:    if (start) state_nxt = S_INPUT_A;
      S_INPUT_A: if (last_in) state_nxt = S_INPUT_B;
      S_INPUT_B: if (last_in) state_nxt = S_HASH;
      S_HASH:    if (rcnt == LAST_ROUND) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        output_valid = 1'b1;
        output_data  = msg[{cnt[1:0], 3'b000} +: 8];
        if (last_out) begin
          if (status_r == ST_WIN) state_nxt = S_IDLE;
`ifdef LOCKPICK_COOLDOWN_EN
          else if (status_r == ST_LOCKED) state_nxt = S_COOLDOWN;
`else
          else if (status_r == ST_LOCKED) state_nxt = S_IDLE;
`endif
          else state_nxt = S_INPUT_A;
        end
      end
`ifdef LOCKPICK_COOLDOWN_EN
      S_COOLDOWN: if (cd_timer == 32'd0) state_nxt = S_IDLE;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_a    <= '0;
      key_b    <= '0;
      {ha, hb, hc, hd} <= '0;
      cnt      <= '0;
      rcnt     <= '0;
      status_r <= ST_IDLE;
      att      <= ATT_MAX;
      msg      <= '0;
    end else begin
      if (state_nxt != state &&
          (state_nxt == S_INPUT_A || state_nxt == S_INPUT_B || state_nxt == S_OUTPUT))
        cnt <= '0;
      else if (in_fire || out_fire)
        cnt <= cnt + 1'b1;

      if (in_fire && state == S_INPUT_A) key_a[{cnt, 3'b000} +: 8] <= input_data;
      if (in_fire && state == S_INPUT_B) key_b <= key_b_wr;

      // Hash lanes: loaded from X on the last key byte, then one round per HASH cycle.
      if (last_in && state == S_INPUT_B) begin
        {ha, hb, hc, hd} <= key_a ^ key_b_wr;
        rcnt <= '0;
      end else if (state == S_HASH) begin
        {ha, hb, hc, hd} <= {ra, rb, rc, rd};
        rcnt <= rcnt + 4'd1;
      end

      if (state == S_COMPARE) begin
        if (match) begin
          status_r <= ST_WIN;
          msg      <= MSG_WIN;
        end else begin
          att <= att_dec;
          if (att_dec == 3'd0) begin
            status_r <= ST_LOCKED;
            msg      <= MSG_LOCKED;
          end else begin
            status_r <= ST_WRONG;
            msg      <= MSG_WRONG;
          end
        end
      end

      if (state_nxt == S_IDLE && state != S_IDLE) begin
        status_r <= ST_IDLE;
        att      <= ATT_MAX;
      end
    end
  end

`ifdef LOCKPICK_COOLDOWN_EN
  // Loaded with N-1 on entry so the block spends exactly N cycles in COOLDOWN.
  always_ff @(posedge clk) begin
    if (rst)
      cd_timer <= '0;
    else if (state != S_COOLDOWN && state_nxt == S_COOLDOWN)
      cd_timer <= 32'(COOLDOWN_CYCLES - 1);
    else if (state == S_COOLDOWN && cd_timer != 32'd0)
      cd_timer <= cd_timer - 32'd1;
  end
`endif

endmodule

// File: tb/tb_lockpick_game_param.sv
// Randomised bench for lockpick_game_param (KEY_BYTES=16, ROUNDS=5) against a behavioural model.
module tb_lockpick_game_param;

  localparam int KB   = 16;
  localparam int RNDS = 5;
  localparam int MAXA = 3;
  localparam int CDC  = 8;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] v);
    return SBOX_TAB[2047 - 8*v -: 8];
  endfunction

  // Hash on 32-bit lanes with shift-based rotations.
  function automatic logic [127:0] model_hash(input logic [127:0] x);
    logic [31:0] a, b, c, d, f;
    a = x[127:96]; b = x[95:64]; c = x[63:32]; d = x[31:0];
    for (int r = 0; r < RNDS; r++) begin
      f = ((b ^ d) + (a | c)) ^ (((c & 32'h0000FFFF) << 16) | (d & 32'h0000FFFF));
      f = ((f << 1) & 32'hFEFEFEFE) | ((f >> 7) & 32'h01010101);
      f = (f << 13) | (f >> 19);
      f = {sb(f[31:24]), sb(f[23:16]), sb(f[15:8]), sb(f[7:0])};
      a = a ^ f;
      b = (b << 17) | (b >> 15);
      c = c + a;
      d = ~d ^ b;
      a = (a << 8) | (a >> 24);
    end
    return {a, b, c, d};
  endfunction

  localparam logic [127:0] WIN_HASH = model_hash(128'h0);
  localparam logic [511:0] CH       = {384'h0, WIN_HASH};

  logic       clk = 1'b0;
  logic       rst, start, input_enable, output_ready;
  logic [7:0] input_data;
  logic       output_valid, busy;
  logic [7:0] output_data;
  logic [1:0] status;
  logic [2:0] attempts_left;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_att;
  bit in_game;

  always #5 clk = ~clk;

  lockpick_game_param #(
    .KEY_BYTES       (KB),
    .ROUNDS          (RNDS),
    .MAX_ATTEMPTS    (MAXA),
    .COOLDOWN_CYCLES (CDC),
    .CHALLENGE       (CH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .input_enable  (input_enable),
    .input_data    (input_data),
    .output_ready  (output_ready),
    .output_valid  (output_valid),
    .output_data   (output_data),
    .status        (status),
    .attempts_left (attempts_left),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    in_game = 1'b1;
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < KB; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clk); input_enable = 1'b0; input_data = 8'($urandom);
      end
      @(negedge clk); input_enable = 1'b1; input_data = k[8*i +: 8];
    end
  endtask

  task automatic play(input logic [127:0] ka, input logic [127:0] kb,
                      input bit toggle_ready, input bit abort_hash);
    logic [127:0] h;
    logic [31:0]  word;
    logic [1:0]   est;
    bit           win, lock;
    int           n, idx, guard;
    if (!in_game) do_start();
    send_key(ka);
    send_key(kb);
    n = 0;
    while (output_valid !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (abort_hash && n == 2) begin
        rst = 1'b1; start = 1'b0; input_enable = 1'b0;
        @(negedge clk); rst = 1'b0;
        chk("rst_valid", output_valid, 0);
        chk("rst_status", status, 0);
        chk("rst_attempts", attempts_left, MAXA);
        chk("rst_busy", busy, 0);
        in_game = 1'b0; exp_att = MAXA;
        return;
      end
      if (output_valid !== 1'b1) begin
        input_enable = 1'($urandom); input_data = 8'($urandom); start = 1'($urandom);
      end
    end
    start = 1'b0;
    chk("latency", n, RNDS + 2);

    h = model_hash(ka ^ kb);
    win = (h == WIN_HASH);
    lock = 1'b0;
    if (win) begin
      est = 2'b10; word = 32'hFACEFACE;
    end else begin
      if (exp_att > 0) exp_att--;
      lock = (exp_att == 0);
      est  = lock ? 2'b11 : 2'b01;
      word = lock ? 32'hDEADDEAD : 32'hBAD0BAD0;
    end
    chk("status", status, est);
    chk("attempts", attempts_left, exp_att);

    idx = 0; guard = 0;
    while (idx < KB && guard < 200) begin
      chk("out_valid", output_valid, 1);
      chk("out_byte", output_data, word[8*(idx%4) +: 8]);
      output_ready = toggle_ready ? (guard % 2 == 0) : 1'($urandom);
      if (output_ready) idx++;
      input_enable = 1'($urandom); input_data = 8'($urandom);
`ifdef LOCKPICK_COOLDOWN_EN
      if (idx == KB && lock) start = 1'b1;
`endif
      @(negedge clk); guard++;
    end
    output_ready = 1'b0; input_enable = 1'b0;
    chk("stream_done", idx, KB);
    chk("valid_drop", output_valid, 0);

    if (win) begin
      chk("win_busy", busy, 0); chk("win_status", status, 0);
      chk("win_attempts", attempts_left, MAXA);
      in_game = 1'b0; exp_att = MAXA;
    end else if (lock) begin
`ifdef LOCKPICK_COOLDOWN_EN
      for (int i = 0; i < CDC; i++) begin
        chk("cd_busy", busy, 1); chk("cd_status", status, 3);
        @(negedge clk);
      end
      chk("cd_idle", busy, 0);
      @(negedge clk);
      chk("cd_restart_busy", busy, 1); chk("cd_restart_status", status, 0);
      chk("cd_restart_attempts", attempts_left, MAXA);
      start = 1'b0; in_game = 1'b1; exp_att = MAXA;
`else
      chk("lock_busy", busy, 0); chk("lock_status", status, 0);
      chk("lock_attempts", attempts_left, MAXA);
      in_game = 1'b0; exp_att = MAXA;
`endif
    end else begin
      chk("wrong_busy", busy, 1); chk("wrong_status", status, 1);
      chk("wrong_attempts", attempts_left, exp_att);
      in_game = 1'b1;
    end
  endtask

  initial begin
    logic [127:0] k;
    rst = 1'b1; start = 1'b0; input_enable = 1'b0; input_data = 8'h00; output_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", output_valid, 0);
    chk("reset_data", output_data, 0);
    chk("reset_status", status, 0);
    chk("reset_attempts", attempts_left, MAXA);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    exp_att = MAXA; in_game = 1'b0;

    play({KB{8'h11}}, {KB{8'h11}}, 1'b0, 1'b0);   // win with the model hash of X=0
    play(rand_key(), rand_key(), 1'b1, 1'b0);     // wrong, toggling ready
    play(rand_key(), rand_key(), 1'b0, 1'b1);     // reset during the 2nd HASH cycle
    play(rand_key(), rand_key(), 1'b1, 1'b0);
    play(rand_key(), rand_key(), 1'b0, 1'b0);
    play(rand_key(), rand_key(), 1'b0, 1'b0);     // lockout
    k = rand_key();
    play(k, k, 1'b1, 1'b0);                       // equal keys give X=0, a win
    for (int g = 0; g < 4; g++) begin
      k = rand_key();
      play(k, ($urandom_range(0, 1) == 1) ? k : rand_key(), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
